// File: rtl/periph_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// periph_bus_master_pkg
//   Shared definitions for the peripheral bus initiator: signal levels for the
//   chip-select/strobe/direction lines, the FSM state encoding, and a helper
//   that sizes the watchdog counter.
// -----------------------------------------------------------------------------
package periph_bus_master_pkg;

    // Signal levels on the peripheral bus.
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic READ    = 1'b1;
    localparam logic WRITE   = 1'b0;

    localparam int WORD_DATA_W = 32;

    typedef enum logic [1:0] {
        BUS_ST_IDLE = 2'd0,
        BUS_ST_ADDR = 2'd1,
        BUS_ST_WAIT = 2'd2,
        BUS_ST_RESP = 2'd3
    } bus_st_e;

    // Width needed to count 0..timeout; never narrower than one bit so that
    // TIMEOUT = 0 (wait forever) still elaborates.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_master_watchdog.sv
// -----------------------------------------------------------------------------
// bus_master_watchdog
//   Counts the cycles a bus access has been outstanding and flags expiry once
//   the count reaches TIMEOUT. The counter saturates there. TIMEOUT = 0
//   disables expiry entirely.
// Ports
//   clk       in   system clock
//   rest      in   asynchronous, active-high reset
//   clear_i   in   force the count back to zero (takes priority over enable_i)
//   enable_i  in   count this cycle
//   expired_o out  count has reached TIMEOUT
// -----------------------------------------------------------------------------
module bus_master_watchdog
    import periph_bus_master_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rest,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int                CNT_W = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/periph_bus_master.sv
// -----------------------------------------------------------------------------
// periph_bus_master
//   Initiator side of the peripheral bus. Accepts one request at a time from
//   the core/DMA request port, decodes the chip select from the upper address
//   bits, drives one address-strobe cycle, waits for rdy under a watchdog and
//   returns read data / timeout status as a one-cycle response strobe.
//   All outputs are registered. FSM: IDLE -> ADDR -> (WAIT) -> RESP -> IDLE.
// Ports
//   clk, rest                    clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_rw/req_addr/req_wdata    direction, {slave index, register}, data
//   rsp_valid                    one-cycle response strobe, no backpressure
//   rsp_rdata/rsp_err            read data (0 on write/error), timeout flag;
//                                both hold their value after the strobe
//   bus_cs/bus_as/bus_rw         one-hot select, address strobe, direction
//   bus_addr/bus_wr_data         register address, write data (0 on reads)
//   bus_rdy/bus_rd_data          OR of all slaves' rdy / read data
// -----------------------------------------------------------------------------
module periph_bus_master
    import periph_bus_master_pkg::*;
#(
    parameter  int DATA_W  = WORD_DATA_W,
    parameter  int ADDR_W  = 3,
    parameter  int NUM_CS  = 4,
    parameter  int TIMEOUT = 16,
    localparam int CS_W    = $clog2(NUM_CS)
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_rw,
    input  logic [CS_W+ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [NUM_CS-1:0]      bus_cs,
    output logic                   bus_as,
    output logic                   bus_rw,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wr_data,
    input  logic                   bus_rdy,
    input  logic [DATA_W-1:0]      bus_rd_data
);

    bus_st_e             state_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [NUM_CS-1:0]   bus_cs_q;
    logic                bus_as_q;
    logic                bus_rw_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wr_data_q;

    logic                wdog_expired;
    logic [NUM_CS-1:0]   cs_onehot;

    // Chip-select decode of the slave index carried in the upper address bits.
    always_comb begin
        cs_onehot = {NUM_CS{DISABLE}};
        cs_onehot[req_addr[CS_W+ADDR_W-1:ADDR_W]] = ENABLE;
    end

    // The watchdog is cleared while idle and counts every ADDR/WAIT cycle, so
    // in the k-th WAIT cycle it holds k and expires in WAIT cycle TIMEOUT.
    bus_master_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rest      (rest),
        .clear_i   (state_q == BUS_ST_IDLE),
        .enable_i  ((state_q == BUS_ST_ADDR) || (state_q == BUS_ST_WAIT)),
        .expired_o (wdog_expired)
    );

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q       <= BUS_ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            bus_cs_q      <= {NUM_CS{DISABLE}};
            bus_as_q      <= DISABLE;
            bus_rw_q      <= READ;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
        end else begin
            unique case (state_q)
                BUS_ST_IDLE: begin
                    // The bus registers double as the latched request.
                    if (req_valid && req_ready_q) begin
                        state_q       <= BUS_ST_ADDR;
                        req_ready_q   <= 1'b0;
                        bus_cs_q      <= cs_onehot;
                        bus_as_q      <= ENABLE;
                        bus_rw_q      <= req_rw;
                        bus_addr_q    <= req_addr[ADDR_W-1:0];
                        bus_wr_data_q <= (req_rw == WRITE) ? req_wdata : '0;
                    end
                end

                BUS_ST_ADDR, BUS_ST_WAIT: begin
                    bus_as_q <= DISABLE;
                    if (bus_rdy || ((state_q == BUS_ST_WAIT) && wdog_expired)) begin
                        state_q     <= BUS_ST_RESP;
                        rsp_valid_q <= 1'b1;
                        // rdy wins over a timeout on the same edge.
                        rsp_err_q   <= !bus_rdy;
                        rsp_rdata_q <= (bus_rdy && (bus_rw_q == READ)) ? bus_rd_data : '0;
                        bus_cs_q      <= {NUM_CS{DISABLE}};
                        bus_rw_q      <= READ;
                        bus_addr_q    <= '0;
                        bus_wr_data_q <= '0;
                    end else begin
                        state_q <= BUS_ST_WAIT;
                    end
                end

                BUS_ST_RESP: begin
                    state_q     <= BUS_ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end

                default: state_q <= BUS_ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign bus_cs      = bus_cs_q;
    assign bus_as      = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_master
//   Drives directed requests into periph_bus_master against a small world of
//   bus slaves with per-slave wait states (or none present). A transaction-level
//   model predicts, from each accepted request, the response cycle, data and
//   error flag plus the bus pattern in every cycle; a compare process checks the
//   DUT against it on every falling edge. Directed tasks add literal checks.
// -----------------------------------------------------------------------------
module tb_periph_bus_master;
    import periph_bus_master_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 3;
    localparam int NUM_CS  = 4;
    localparam int CS_W    = 2;
    localparam int TIMEOUT = 16;
    localparam int ABSENT  = -1;

    localparam logic [ADDR_W-1:0] TIMER_CTRL_ADDR = 3'd0;
    localparam logic [DATA_W-1:0] TIMER_CIRCLE_UP = 32'h0000_0003;

    logic                   clk = 1'b0;
    logic                   rest = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   req_rw = READ;
    logic [CS_W+ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0]      req_wdata = '0;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [NUM_CS-1:0]      bus_cs;
    logic                   bus_as;
    logic                   bus_rw;
    logic [ADDR_W-1:0]      bus_addr;
    logic [DATA_W-1:0]      bus_wr_data;
    logic                   bus_rdy;
    logic [DATA_W-1:0]      bus_rd_data;

    always #5 clk = ~clk;

    periph_bus_master #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_CS (NUM_CS), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rest (rest),
        .req_valid (req_valid), .req_ready (req_ready), .req_rw (req_rw),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .bus_cs (bus_cs), .bus_as (bus_as), .bus_rw (bus_rw),
        .bus_addr (bus_addr), .bus_wr_data (bus_wr_data),
        .bus_rdy (bus_rdy), .bus_rd_data (bus_rd_data)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_val(input int s, input int r);
        return 32'hC0DE_0000 | DATA_W'(s << 8) | DATA_W'(r);
    endfunction

    // ---------------- slave world ----------------
    // slave_wait[s]: rdy comes in access cycle N (0 = the ADDR cycle), or ABSENT.
    int                slave_wait [NUM_CS] = '{0, 2, 5, ABSENT};
    logic [DATA_W-1:0] slave_mem  [NUM_CS][8];
    int                acc_cyc;
    logic              spur_rdy = 1'b0;
    logic              slave_rdy;
    logic [CS_W-1:0]   sel_idx;
    logic              sel_hit;

    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (bus_cs[i]) begin
                sel_idx = CS_W'(i);
                sel_hit = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge rest) begin
        if (rest)          acc_cyc <= 0;
        else if (bus_as)   acc_cyc <= 1;
        else if (|bus_cs)  acc_cyc <= acc_cyc + 1;
        else               acc_cyc <= 0;
    end

    assign slave_rdy   = sel_hit && (slave_wait[sel_idx] >= 0) &&
                         ((bus_as ? 0 : acc_cyc) == slave_wait[sel_idx]);
    assign bus_rdy     = slave_rdy | spur_rdy;
    assign bus_rd_data = (slave_rdy && bus_rw == READ) ? slave_mem[sel_idx][bus_addr] : '0;

    // Slave registers reset with the system.
    always @(posedge clk or posedge rest) begin
        if (rest) begin
            for (int s = 0; s < NUM_CS; s++)
                for (int r = 0; r < 8; r++) slave_mem[s][r] <= init_val(s, r);
        end else if (slave_rdy && bus_rw == WRITE) begin
            slave_mem[sel_idx][bus_addr] <= bus_wr_data;
        end
    end

    // ---------------- transaction model + compare ----------------
    typedef struct {
        int                acc;     // falling-edge index at which it was accepted
        int                due;     // falling-edge index of the response cycle
        logic              rw;
        logic [CS_W-1:0]   idx;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } txn_t;

    txn_t              cur;
    bit                busy = 0;
    int                k = 0;
    int                rsp_count = 0;
    logic [DATA_W-1:0] shadow [NUM_CS][8];
    logic [DATA_W-1:0] last_rdata;
    logic              last_err;

    initial begin
        forever begin
            @(negedge clk);
            k++;
            if (rest) begin
                busy = 0;
                last_rdata = '0;
                last_err   = 1'b0;
                for (int s = 0; s < NUM_CS; s++)
                    for (int r = 0; r < 8; r++) shadow[s][r] = init_val(s, r);
                check("rst_req_ready", req_ready, 1);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_rdata", rsp_rdata, 0);
                check("rst_rsp_err", rsp_err, 0);
                check("rst_bus_cs", bus_cs, 0);
                check("rst_bus_as", bus_as, 0);
                check("rst_bus_rw", bus_rw, READ);
                check("rst_bus_addr", bus_addr, 0);
                check("rst_bus_wr_data", bus_wr_data, 0);
            end else begin
                bit                in_addr, in_wait, in_resp, on_bus, exp_ready;
                logic [NUM_CS-1:0] exp_cs;
                in_addr   = busy && (k == cur.acc + 1);
                in_wait   = busy && (k > cur.acc + 1) && (k < cur.due);
                in_resp   = busy && (k == cur.due);
                on_bus    = in_addr || in_wait;
                exp_ready = !(busy && k > cur.acc);
                exp_cs    = '0;
                if (on_bus) exp_cs[cur.idx] = 1'b1;
                if (in_resp) begin
                    last_rdata = cur.rdata;
                    last_err   = cur.err;
                    rsp_count++;
                end
                check("req_ready", req_ready, exp_ready);
                check("rsp_valid", rsp_valid, in_resp);
                check("rsp_rdata", rsp_rdata, last_rdata);
                check("rsp_err", rsp_err, last_err);
                check("bus_cs", bus_cs, exp_cs);
                check("bus_as", bus_as, in_addr);
                check("bus_rw", bus_rw, on_bus ? cur.rw : READ);
                check("bus_addr", bus_addr, on_bus ? cur.addr : '0);
                check("bus_wr_data", bus_wr_data,
                      (on_bus && cur.rw == WRITE) ? cur.wdata : '0);
                if (in_resp) busy = 0;
                if (req_valid && exp_ready) begin
                    int w;
                    cur.acc   = k;
                    cur.rw    = req_rw;
                    cur.idx   = req_addr[CS_W+ADDR_W-1:ADDR_W];
                    cur.addr  = req_addr[ADDR_W-1:0];
                    cur.wdata = req_wdata;
                    w = slave_wait[cur.idx];
                    if (w >= 0 && w <= TIMEOUT) begin
                        cur.due = k + 2 + w;
                        cur.err = 1'b0;
                        if (req_rw == READ) begin
                            cur.rdata = shadow[cur.idx][cur.addr];
                        end else begin
                            cur.rdata = '0;
                            shadow[cur.idx][cur.addr] = req_wdata;
                        end
                    end else begin
                        cur.due   = k + 2 + TIMEOUT;
                        cur.err   = 1'b1;
                        cur.rdata = '0;
                    end
                    busy = 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_req(input logic rw, input logic [CS_W+ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
        bit ok = 0;
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
        end
        check("accept_within_bound", ok, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic transact(input logic rw, input logic [CS_W+ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata,
                            output logic [DATA_W-1:0] rdata, output logic err,
                            output int lat, output int as_cycles,
                            output logic [NUM_CS-1:0] cs_first, output logic rw_first);
        rdata = '0; err = 1'b0; lat = 0; as_cycles = 0; cs_first = '0; rw_first = READ;
        drive_req(rw, addr, wdata);
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (bus_as) as_cycles++;
            if (i == 1) begin cs_first = bus_cs; rw_first = bus_rw; end
            if (rsp_valid) begin lat = i; rdata = rsp_rdata; err = rsp_err; end
        end
        check("rsp_within_bound", lat != 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic              er;
        logic [NUM_CS-1:0] cs1;
        logic              rw1;
        int                lat, asn, base;
        bit                ok;

        repeat (3) @(posedge clk);
        #1 rest = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1. Timer (cs 1, 2 wait states): write ctrl.
        transact(WRITE, {2'd1, TIMER_CTRL_ADDR}, TIMER_CIRCLE_UP, rd, er, lat, asn, cs1, rw1);
        check("t1_bus_cs", cs1, 4'b0010);
        check("t1_bus_rw", rw1, WRITE);
        check("t1_as_cycles", asn, 1);
        check("t1_err", er, 0);
        check("t1_latency", lat, 4);

        // 2. Read it back.
        transact(READ, {2'd1, TIMER_CTRL_ADDR}, 32'hFFFF_FFFF, rd, er, lat, asn, cs1, rw1);
        check("t2_rdata", rd, TIMER_CIRCLE_UP);
        check("t2_err", er, 0);

        // 3. Zero-wait slave: minimum latency.
        transact(READ, {2'd0, 3'd5}, '0, rd, er, lat, asn, cs1, rw1);
        check("t3_latency", lat, 2);
        check("t3_rdata", rd, 32'hC0DE_0005);
        transact(WRITE, {2'd0, 3'd2}, 32'h1234_5678, rd, er, lat, asn, cs1, rw1);
        check("t3_wr_rdata_zero", rd, 0);
        transact(READ, {2'd0, 3'd2}, '0, rd, er, lat, asn, cs1, rw1);
        check("t3_readback", rd, 32'h1234_5678);

        // rdy while idle must be ignored.
        spur_rdy = 1'b1;
        repeat (5) @(posedge clk);
        #1 spur_rdy = 1'b0;

        // 4. No slave at cs 3: timeout; then rdy exactly on the timeout cycle; then one past.
        transact(READ, {2'd3, 3'd1}, '0, rd, er, lat, asn, cs1, rw1);
        check("t4_timeout_err", er, 1);
        check("t4_timeout_rdata", rd, 0);
        check("t4_timeout_latency", lat, 18);
        slave_wait[3] = 16;
        transact(READ, {2'd3, 3'd4}, '0, rd, er, lat, asn, cs1, rw1);
        check("t4_rdy_wins_err", er, 0);
        check("t4_rdy_wins_rdata", rd, 32'hC0DE_0304);
        check("t4_rdy_wins_latency", lat, 18);
        slave_wait[3] = 17;
        transact(WRITE, {2'd3, 3'd4}, 32'hDEAD_BEEF, rd, er, lat, asn, cs1, rw1);
        check("t4_late_rdy_err", er, 1);
        slave_wait[3] = ABSENT;

        // 5. req_valid held high across three requests.
        base = rsp_count;
        req_valid = 1'b1; req_rw = WRITE; req_addr = {2'd2, 3'd1}; req_wdata = 32'hAAAA_0001;
        for (int n = 0; n < 3; n++) begin
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                if (req_ready) ok = 1;
            end
            check("t5_accept_bound", ok, 1);
            @(posedge clk); #1;
            if (n == 0) begin req_rw = READ;  req_addr = {2'd2, 3'd1}; req_wdata = '0; end
            if (n == 1) begin req_rw = WRITE; req_addr = {2'd0, 3'd7}; req_wdata = 32'hBBBB_0002; end
            if (n == 2) req_valid = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        check("t5_responses", rsp_count - base, 3);
        transact(READ, {2'd0, 3'd7}, '0, rd, er, lat, asn, cs1, rw1);
        check("t5_last_write", rd, 32'hBBBB_0002);

        // 6. Reset pulse during WAIT on an absent slave.
        drive_req(READ, {2'd3, 3'd0}, '0);
        repeat (4) @(posedge clk);
        #1 rest = 1'b1;
        @(negedge clk);
        check("t6_cs_released", bus_cs, 0);
        check("t6_as_released", bus_as, 0);
        @(posedge clk);
        #1 rest = 1'b0;
        base = rsp_count;
        repeat (25) @(posedge clk);
        #1;
        check("t6_no_rsp", rsp_count - base, 0);
        transact(READ, {2'd1, TIMER_CTRL_ADDR}, '0, rd, er, lat, asn, cs1, rw1);
        check("t6_after_reset_rdata", rd, 32'hC0DE_0100);
        check("t6_after_reset_latency", lat, 4);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation exceeded time bound");
        $fatal(1, "time limit");
    end

endmodule
